// File: rtl/dccm_port_arbiter_pkg.sv
// dccm_port_arbiter_pkg: shared types and defaults for the DCCM port arbiter.
package dccm_port_arbiter_pkg;
    localparam int DCCM_XLEN = 32;
    localparam int DCCM_AW = 32;
    localparam int DCCM_ARB_STARVE_LIMIT = 8;

    typedef enum logic [1:0] {ARB_NONE, ARB_LSU, ARB_DMA} arb_owner_e;

    typedef struct packed {
        logic                   wen;
        logic [DCCM_AW-1:0]     addr;
        logic [DCCM_XLEN-1:0]   wdata;
        logic [DCCM_XLEN/8-1:0] wmask;
    } dccm_req_t;
endpackage

// File: rtl/dccm_port_arbiter_if.sv
// dccm_port_arbiter_if: LSU/DMA request-response channels and the DCCM macro port.
interface dccm_port_arbiter_if
    import dccm_port_arbiter_pkg::*;
#(
    parameter int XLEN = DCCM_XLEN,
    parameter int AW = DCCM_AW
);
    logic              lsu_req_valid, lsu_req_ready, lsu_req_wen;
    logic [AW-1:0]     lsu_req_addr;
    logic [XLEN-1:0]   lsu_req_wdata;
    logic [XLEN/8-1:0] lsu_req_wmask;
    logic              lsu_rsp_valid;
    logic [XLEN-1:0]   lsu_rsp_rdata;
    logic              dma_req_valid, dma_req_ready, dma_req_wen;
    logic [AW-1:0]     dma_req_addr;
    logic [XLEN-1:0]   dma_req_wdata;
    logic [XLEN/8-1:0] dma_req_wmask;
    logic              dma_rsp_valid;
    logic [XLEN-1:0]   dma_rsp_rdata;
    logic              dccm_ren, dccm_wen;
    logic [AW-1:0]     dccm_raddr, dccm_waddr;
    logic [XLEN-1:0]   dccm_wdata, dccm_rdata;
    logic [XLEN/8-1:0] dccm_wmask;

    modport slave (
        input  lsu_req_valid, lsu_req_wen, lsu_req_addr, lsu_req_wdata, lsu_req_wmask,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
        input  dma_req_valid, dma_req_wen, dma_req_addr, dma_req_wdata, dma_req_wmask,
        output dma_req_ready, dma_rsp_valid, dma_rsp_rdata,
        output dccm_ren, dccm_raddr, dccm_wen, dccm_waddr, dccm_wdata, dccm_wmask,
        input  dccm_rdata
    );

    modport master (
        output lsu_req_valid, lsu_req_wen, lsu_req_addr, lsu_req_wdata, lsu_req_wmask,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
        output dma_req_valid, dma_req_wen, dma_req_addr, dma_req_wdata, dma_req_wmask,
        input  dma_req_ready, dma_rsp_valid, dma_rsp_rdata,
        input  dccm_ren, dccm_raddr, dccm_wen, dccm_waddr, dccm_wdata, dccm_wmask,
        output dccm_rdata
    );
endinterface

// File: rtl/dccm_port_arbiter_starve_ctr.sv
// dccm_arb_starve_ctr: saturating count of consecutive blocked DMA cycles.
module dccm_arb_starve_ctr
    import dccm_port_arbiter_pkg::*;
#(
    parameter int LIMIT = DCCM_ARB_STARVE_LIMIT,
    parameter int W = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);
    logic [W-1:0] cnt_q, cnt_d;

    assign at_limit_o = cnt_q == W'(LIMIT);

    always_comb cnt_d = clr_i ? '0 : (inc_i && !at_limit_o) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) cnt_q <= rstn ? cnt_d : '0;
endmodule

// File: rtl/dccm_port_arbiter.sv
// dccm_port_arbiter: LSU-priority DCCM port sharing with a DMA starvation guard.
// Define DCCM_ARB_PERF_CNT_EN to add saturating grant/force performance counters.
module dccm_port_arbiter
    import dccm_port_arbiter_pkg::*;
#(
    parameter int XLEN = DCCM_XLEN,
    parameter int AW = DCCM_AW,
    parameter int STARVE_LIMIT = DCCM_ARB_STARVE_LIMIT,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rstn,
    dccm_port_arbiter_if.slave bus
`ifdef DCCM_ARB_PERF_CNT_EN
    ,
    output logic [31:0] lsu_gnt_cnt,
    output logic [31:0] dma_gnt_cnt,
    output logic [31:0] dma_force_cnt
`endif
);
    logic            at_limit, force_dma, gnt_dma, gnt_lsu, dma_blocked;
    logic            wen_q, wen_d, lsu_rsp_valid, dma_rsp_valid;
    arb_owner_e      owner_q, owner_d;
    dccm_req_t       lsu_req, dma_req, sel;
    logic [XLEN-1:0] lsu_rdata_q, lsu_rdata_d, dma_rdata_q, dma_rdata_d;
    logic [XLEN-1:0] rsp_data, lsu_rsp_rdata, dma_rsp_rdata;

    assign lsu_req = '{bus.lsu_req_wen, bus.lsu_req_addr, bus.lsu_req_wdata, bus.lsu_req_wmask};
    assign dma_req = '{bus.dma_req_wen, bus.dma_req_addr, bus.dma_req_wdata, bus.dma_req_wmask};

    // Grants are masked during reset so nothing reaches the macro while rstn is low.
    always_comb begin
        force_dma = at_limit & bus.dma_req_valid;
        gnt_dma = rstn & bus.dma_req_valid & (~bus.lsu_req_valid | force_dma);
        gnt_lsu = rstn & bus.lsu_req_valid & ~gnt_dma;
        sel = gnt_dma ? dma_req : gnt_lsu ? lsu_req : '0;
    end

    assign dma_blocked = bus.dma_req_valid & ~gnt_dma;

    dccm_arb_starve_ctr #(.LIMIT(STARVE_LIMIT), .W(CNT_W)) u_starve (
        .clk(clk),
        .rstn(rstn),
        .inc_i(dma_blocked),
        .clr_i(~dma_blocked),
        .at_limit_o(at_limit)
    );

    assign bus.lsu_req_ready = gnt_lsu;
    assign bus.dma_req_ready = gnt_dma;
    assign bus.dccm_ren = (gnt_lsu | gnt_dma) & ~sel.wen;
    assign bus.dccm_wen = (gnt_lsu | gnt_dma) & sel.wen;
    assign bus.dccm_raddr = bus.dccm_ren ? sel.addr : '0;
    assign bus.dccm_waddr = bus.dccm_wen ? sel.addr : '0;
    assign bus.dccm_wdata = bus.dccm_wen ? sel.wdata : '0;
    assign bus.dccm_wmask = bus.dccm_wen ? sel.wmask : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            owner_q <= ARB_NONE;
            wen_q <= 1'b0;
            lsu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            owner_q <= owner_d;
            wen_q <= wen_d;
            lsu_rdata_q <= lsu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    always_comb begin
        owner_d = gnt_dma ? ARB_DMA : gnt_lsu ? ARB_LSU : ARB_NONE;
        wen_d = sel.wen;
        lsu_rdata_d = lsu_rsp_rdata;
        dma_rdata_d = dma_rsp_rdata;
    end

    // The non-owner keeps presenting its last response data.
    always_comb begin
        rsp_data = wen_q ? '0 : bus.dccm_rdata;
        lsu_rsp_valid = rstn && owner_q == ARB_LSU;
        dma_rsp_valid = rstn && owner_q == ARB_DMA;
        lsu_rsp_rdata = lsu_rsp_valid ? rsp_data : lsu_rdata_q;
        dma_rsp_rdata = dma_rsp_valid ? rsp_data : dma_rdata_q;
    end

    assign bus.lsu_rsp_valid = lsu_rsp_valid;
    assign bus.dma_rsp_valid = dma_rsp_valid;
    assign bus.lsu_rsp_rdata = lsu_rsp_rdata;
    assign bus.dma_rsp_rdata = dma_rsp_rdata;

`ifdef DCCM_ARB_PERF_CNT_EN
    logic [31:0] lsu_gnt_q, dma_gnt_q, dma_force_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lsu_gnt_q <= '0;
            dma_gnt_q <= '0;
            dma_force_q <= '0;
        end else begin
            lsu_gnt_q <= lsu_gnt_q + 32'(gnt_lsu && lsu_gnt_q != '1);
            dma_gnt_q <= dma_gnt_q + 32'(gnt_dma && dma_gnt_q != '1);
            dma_force_q <= dma_force_q + 32'(gnt_dma && force_dma && bus.lsu_req_valid && dma_force_q != '1);
        end
    end

    assign lsu_gnt_cnt = lsu_gnt_q;
    assign dma_gnt_cnt = dma_gnt_q;
    assign dma_force_cnt = dma_force_q;
`endif
endmodule

// File: tb/tb_dccm_port_arbiter.sv
// tb_dccm_port_arbiter: directed and random stimulus checked against a cycle-level
// behavioural model of the arbitration, starvation and response-routing rules.
module tb_dccm_port_arbiter;
    import dccm_port_arbiter_pkg::*;

    localparam int LIM = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dccm_port_arbiter_if bus ();

`ifdef DCCM_ARB_PERF_CNT_EN
    logic [31:0] lsu_gnt_cnt, dma_gnt_cnt, dma_force_cnt;
`endif

    dccm_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
`ifdef DCCM_ARB_PERF_CNT_EN
        ,
        .lsu_gnt_cnt(lsu_gnt_cnt),
        .dma_gnt_cnt(dma_gnt_cnt),
        .dma_force_cnt(dma_force_cnt)
`endif
    );

    int total = 0;
    int bad = 0;

    // Model state: grant owner codes 0=none, 1=LSU, 2=DMA.
    int          blocked = 0;
    int          owner = 0;
    int          last_g = 0;
    bit          rd = 0;
    logic [31:0] lsu_hold = 0, dma_hold = 0;
    logic [31:0] n_lsu = 0, n_dma = 0, n_force = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_lsu(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.lsu_req_valid = v;
        bus.lsu_req_wen = w;
        bus.lsu_req_addr = a;
        bus.lsu_req_wdata = d;
        bus.lsu_req_wmask = m;
    endtask

    task automatic set_dma(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.dma_req_valid = v;
        bus.dma_req_wen = w;
        bus.dma_req_addr = a;
        bus.dma_req_wdata = d;
        bus.dma_req_wmask = m;
    endtask

    task automatic rnd_lsu(input bit v);
        set_lsu(v, 1'($urandom), $urandom & 32'h0000_FFFC, $urandom, 4'($urandom));
    endtask

    task automatic rnd_dma(input bit v);
        set_dma(v, 1'($urandom), $urandom & 32'h003F_FFFC, $urandom, 4'($urandom));
    endtask

    // One clock: check all outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        int g;
        bit w;
        logic [31:0] a, d, ersp;
        logic [3:0] m;
        @(negedge clk);
        g = !rstn ? 0 : (bus.dma_req_valid && (!bus.lsu_req_valid || blocked >= LIM)) ? 2 : bus.lsu_req_valid ? 1 : 0;
        w = g == 1 ? bus.lsu_req_wen : g == 2 ? bus.dma_req_wen : 1'b0;
        a = g == 1 ? bus.lsu_req_addr : g == 2 ? bus.dma_req_addr : 32'h0;
        d = g == 1 ? bus.lsu_req_wdata : g == 2 ? bus.dma_req_wdata : 32'h0;
        m = g == 1 ? bus.lsu_req_wmask : g == 2 ? bus.dma_req_wmask : 4'h0;
        chk("lsu_req_ready", 32'(bus.lsu_req_ready), 32'(g == 1));
        chk("dma_req_ready", 32'(bus.dma_req_ready), 32'(g == 2));
        chk("dccm_ren", 32'(bus.dccm_ren), 32'(g != 0 && !w));
        chk("dccm_wen", 32'(bus.dccm_wen), 32'(g != 0 && w));
        chk("dccm_raddr", bus.dccm_raddr, (g != 0 && !w) ? a : 32'h0);
        chk("dccm_waddr", bus.dccm_waddr, (g != 0 && w) ? a : 32'h0);
        chk("dccm_wdata", bus.dccm_wdata, (g != 0 && w) ? d : 32'h0);
        chk("dccm_wmask", 32'(bus.dccm_wmask), (g != 0 && w) ? 32'(m) : 32'h0);
        ersp = rd ? bus.dccm_rdata : 32'h0;
        chk("lsu_rsp_valid", 32'(bus.lsu_rsp_valid), 32'(rstn && owner == 1));
        chk("dma_rsp_valid", 32'(bus.dma_rsp_valid), 32'(rstn && owner == 2));
        chk("lsu_rsp_rdata", bus.lsu_rsp_rdata, (rstn && owner == 1) ? ersp : lsu_hold);
        chk("dma_rsp_rdata", bus.dma_rsp_rdata, (rstn && owner == 2) ? ersp : dma_hold);
`ifdef DCCM_ARB_PERF_CNT_EN
        chk("lsu_gnt_cnt", lsu_gnt_cnt, n_lsu);
        chk("dma_gnt_cnt", dma_gnt_cnt, n_dma);
        chk("dma_force_cnt", dma_force_cnt, n_force);
`endif
        @(posedge clk);
        if (!rstn) begin
            blocked = 0;
            owner = 0;
            rd = 0;
            lsu_hold = 0;
            dma_hold = 0;
            n_lsu = 0;
            n_dma = 0;
            n_force = 0;
            last_g = 0;
        end else begin
            if (owner == 1) lsu_hold = ersp;
            if (owner == 2) dma_hold = ersp;
            if (g == 1) n_lsu++;
            if (g == 2) n_dma++;
            if (g == 2 && bus.lsu_req_valid) n_force++;
            blocked = (bus.dma_req_valid && g != 2) ? (blocked < LIM ? blocked + 1 : LIM) : 0;
            owner = g;
            rd = g != 0 && !w;
            last_g = g;
        end
        #1;
    endtask

    initial begin
        bus.dccm_rdata = 32'h0;
        set_lsu(1, 0, 32'h40, 32'h0, 4'h0);
        set_dma(1, 1, 32'h80, 32'h5, 4'hF);
        #1;
        repeat (10) cycle();

        rstn = 1'b1;
        set_lsu(0, 0, 0, 0, 0);
        set_dma(0, 0, 0, 0, 0);
        cycle();

        // Solo LSU read; the macro returns DEADBEEF one cycle later.
        set_lsu(1, 0, 32'h100, 32'h0, 4'h0);
        bus.dccm_rdata = $urandom;
        cycle();
        chk("solo_lsu_grant", 32'(last_g), 32'd1);
        set_lsu(0, 0, 0, 0, 0);
        bus.dccm_rdata = 32'hDEAD_BEEF;
        cycle();
        chk("solo_lsu_rdata", bus.lsu_rsp_rdata, 32'hDEAD_BEEF);

        // Solo DMA write: ack carries zero data.
        set_dma(1, 1, 32'h0020_0000, 32'h41, 4'h1);
        cycle();
        set_dma(0, 0, 0, 0, 0);
        bus.dccm_rdata = $urandom;
        cycle();
        chk("solo_dma_ack", bus.dma_rsp_rdata, 32'h0);

        // Continuous contention: DMA wins every ninth cycle.
        rnd_lsu(1);
        rnd_dma(1);
        for (int i = 0; i < 27; i++) begin
            bus.dccm_rdata = $urandom;
            cycle();
            chk("contention_gnt", 32'(last_g), (i % 9 == 8) ? 32'd2 : 32'd1);
            if (last_g == 1) rnd_lsu(1);
            if (last_g == 2) rnd_dma(1);
        end

        // DMA withdraws after 5 blocked cycles; the wait restarts from zero.
        rnd_lsu(1);
        rnd_dma(1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("drop_pre_gnt", 32'(last_g), 32'd1);
            rnd_lsu(1);
        end
        bus.dma_req_valid = 1'b0;
        cycle();
        rnd_lsu(1);
        rnd_dma(1);
        for (int i = 0; i < 9; i++) begin
            bus.dccm_rdata = $urandom;
            cycle();
            chk("drop_post_gnt", 32'(last_g), (i == 8) ? 32'd2 : 32'd1);
            rnd_lsu(1);
        end
        set_dma(0, 0, 0, 0, 0);

        // Random traffic; a pending request keeps its payload until granted.
        for (int i = 0; i < 400; i++) begin
            if (!bus.lsu_req_valid || last_g == 1) rnd_lsu(($urandom % 4) != 0);
            if (!bus.dma_req_valid || last_g == 2) rnd_dma(($urandom % 3) != 0);
            bus.dccm_rdata = $urandom;
            cycle();
        end

        // Reset right after a DMA read grant drops its response.
        set_lsu(0, 0, 0, 0, 0);
        rnd_dma(1);
        bus.dma_req_wen = 1'b0;
        cycle();
        set_dma(0, 0, 0, 0, 0);
        rstn = 1'b0;
        bus.dccm_rdata = 32'hCAFE_F00D;
        cycle();
        chk("reset_drop_rsp", 32'(bus.dma_rsp_valid), 32'd0);
        rstn = 1'b1;
        cycle();
        chk("reset_no_late_rsp", 32'(bus.dma_rsp_valid), 32'd0);

        // Starvation count restarts from zero after reset.
        rnd_lsu(1);
        rnd_dma(1);
        for (int i = 0; i < 9; i++) begin
            cycle();
            chk("post_reset_gnt", 32'(last_g), (i == 8) ? 32'd2 : 32'd1);
            if (last_g == 1) rnd_lsu(1);
        end
        set_lsu(0, 0, 0, 0, 0);
        set_dma(0, 0, 0, 0, 0);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
